// File: rtl/sys_defs.sv
// Shared definitions for the ALU reservation station: widths, function codes,
// entry and dispatch packet layouts.
// Pure declarations; no timing or flow control lives here.
package sys_defs;

  localparam int XLEN        = 32;
  localparam int PRF_LEN     = 6;
  localparam int ROB_LEN     = 5;
  localparam int FUNC_LEN    = 5;
  localparam int RS_ALU_SIZE = 8;

  typedef enum logic [FUNC_LEN-1:0] {
    ALU_ADD  = 5'h00,
    ALU_SUB  = 5'h01,
    ALU_AND  = 5'h02,
    ALU_OR   = 5'h03,
    ALU_XOR  = 5'h04,
    ALU_SLL  = 5'h05,
    ALU_SRL  = 5'h06,
    ALU_SRA  = 5'h07,
    ALU_SLT  = 5'h08,
    ALU_SLTU = 5'h09
  } ALU_FUNC;

  // One reservation station slot.
  typedef struct packed {
    logic                valid;
    logic [FUNC_LEN-1:0] func;
    logic                opa_ready;
    logic [XLEN-1:0]     opa_value;
    logic [PRF_LEN-1:0]  opa_preg;
    logic                opb_ready;
    logic [XLEN-1:0]     opb_value;
    logic [PRF_LEN-1:0]  opb_preg;
    logic [PRF_LEN-1:0]  dest_preg;
    logic [ROB_LEN-1:0]  rob_idx;
    logic [XLEN-1:0]     PC;
  } RS_ALU_ENTRY;

  // Everything dispatch hands over in one cycle.
  typedef struct packed {
    logic                valid;
    logic [FUNC_LEN-1:0] func;
    logic                opa_ready;
    logic [XLEN-1:0]     opa_value;
    logic [PRF_LEN-1:0]  opa_preg;
    logic                opb_ready;
    logic [XLEN-1:0]     opb_value;
    logic [PRF_LEN-1:0]  opb_preg;
    logic [PRF_LEN-1:0]  dest_preg;
    logic [ROB_LEN-1:0]  rob_idx;
    logic [XLEN-1:0]     PC;
  } RS_ALU_DISPATCH_PACKET;

  // True when a still-waiting operand is satisfied by this cycle's CDB broadcast.
  function automatic logic cdb_hit(input logic               op_ready,
                                   input logic [PRF_LEN-1:0] op_preg,
                                   input logic               cdb_valid,
                                   input logic [PRF_LEN-1:0] cdb_preg);
    return !op_ready && cdb_valid && (op_preg == cdb_preg);
  endfunction

endpackage

// File: rtl/rs_psel.sv
// Lowest-index priority selector: one-hot grant of the lowest set request bit.
// Purely combinational, zero latency.
// No flow control; empty flags that no request bit is set.
module rs_psel #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         empty
);

  logic found;

  // Scan upward and grant only the first requester seen.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    empty = !found;
  end

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops until operands arrive via CDB snoop.
// Ready op issues combinationally from entry state; wakeup-to-issue is one cycle.
// issue_valid/issue_ready handshake holds the presented entry; dispatch gated by registered rs_full.
module rs_alu
  import sys_defs::*;
#(
  parameter int RS_SIZE = RS_ALU_SIZE
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic                     dispatch_valid,
  input  logic [FUNC_LEN-1:0]      dispatch_func,
  input  logic                     dispatch_opa_ready,
  input  logic [XLEN-1:0]          dispatch_opa_value,
  input  logic [PRF_LEN-1:0]       dispatch_opa_preg,
  input  logic                     dispatch_opb_ready,
  input  logic [XLEN-1:0]          dispatch_opb_value,
  input  logic [PRF_LEN-1:0]       dispatch_opb_preg,
  input  logic [PRF_LEN-1:0]       dispatch_dest_preg,
  input  logic [ROB_LEN-1:0]       dispatch_rob_idx,
  input  logic [XLEN-1:0]          dispatch_PC,
  input  logic                     cdb_broadcast_valid,
  input  logic [PRF_LEN-1:0]       cdb_dest_preg_idx,
  input  logic [XLEN-1:0]          cdb_broadcast_value,
  input  logic                     issue_ready,
  output logic                     issue_valid,
  output logic [FUNC_LEN-1:0]      issue_func,
  output logic [XLEN-1:0]          issue_opa,
  output logic [XLEN-1:0]          issue_opb,
  output logic [PRF_LEN-1:0]       issue_dest_preg,
  output logic [ROB_LEN-1:0]       issue_rob_idx,
  output logic [XLEN-1:0]          issue_PC,
  output logic                     rs_full,
  output logic [$clog2(RS_SIZE):0] rs_count
);

  localparam int CNT_W = $clog2(RS_SIZE) + 1;

  RS_ALU_ENTRY           entries_q [RS_SIZE];
  RS_ALU_ENTRY           entries_d [RS_SIZE];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;

  RS_ALU_DISPATCH_PACKET disp_pkt;
  RS_ALU_ENTRY           new_entry;
  RS_ALU_ENTRY           sel_entry;

  logic [RS_SIZE-1:0]    free_req, alloc_gnt;
  logic [RS_SIZE-1:0]    ready_req, issue_gnt;
  logic                  alloc_empty, issue_empty;
  logic                  alloc, issue_fire;

  // Bundle the dispatch inputs into one packet.
  always_comb begin
    disp_pkt.valid     = dispatch_valid;
    disp_pkt.func      = dispatch_func;
    disp_pkt.opa_ready = dispatch_opa_ready;
    disp_pkt.opa_value = dispatch_opa_value;
    disp_pkt.opa_preg  = dispatch_opa_preg;
    disp_pkt.opb_ready = dispatch_opb_ready;
    disp_pkt.opb_value = dispatch_opb_value;
    disp_pkt.opb_preg  = dispatch_opb_preg;
    disp_pkt.dest_preg = dispatch_dest_preg;
    disp_pkt.rob_idx   = dispatch_rob_idx;
    disp_pkt.PC        = dispatch_PC;
  end

  // Request vectors: free slots for allocation, fully-ready slots for issue.
  always_comb begin
    free_req  = '0;
    ready_req = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_req[i]  = !entries_q[i].valid;
      ready_req[i] = entries_q[i].valid && entries_q[i].opa_ready && entries_q[i].opb_ready;
    end
  end

  rs_psel #(.N(RS_SIZE)) u_alloc_sel (
    .req   (free_req),
    .gnt   (alloc_gnt),
    .empty (alloc_empty)
  );

  rs_psel #(.N(RS_SIZE)) u_issue_sel (
    .req   (ready_req),
    .gnt   (issue_gnt),
    .empty (issue_empty)
  );

  // Mux the granted entry onto the issue port; all-zero when nothing is ready.
  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (issue_gnt[i]) begin
        sel_entry = entries_q[i];
      end
    end
  end

  assign issue_valid     = !issue_empty && !squash;
  assign issue_func      = sel_entry.func;
  assign issue_opa       = sel_entry.opa_value;
  assign issue_opb       = sel_entry.opb_value;
  assign issue_dest_preg = sel_entry.dest_preg;
  assign issue_rob_idx   = sel_entry.rob_idx;
  assign issue_PC        = sel_entry.PC;

  assign issue_fire = issue_valid && issue_ready;
  // rs_full is the registered view, so a slot freed this cycle cannot be refilled until next cycle.
  assign alloc      = disp_pkt.valid && !full_q && !alloc_empty && !squash;

  // Build the incoming entry, capturing a same-cycle CDB broadcast so no wakeup is lost.
  always_comb begin
    new_entry.valid     = 1'b1;
    new_entry.func      = disp_pkt.func;
    new_entry.opa_ready = disp_pkt.opa_ready;
    new_entry.opa_value = disp_pkt.opa_value;
    new_entry.opa_preg  = disp_pkt.opa_preg;
    new_entry.opb_ready = disp_pkt.opb_ready;
    new_entry.opb_value = disp_pkt.opb_value;
    new_entry.opb_preg  = disp_pkt.opb_preg;
    new_entry.dest_preg = disp_pkt.dest_preg;
    new_entry.rob_idx   = disp_pkt.rob_idx;
    new_entry.PC        = disp_pkt.PC;
    if (cdb_hit(disp_pkt.opa_ready, disp_pkt.opa_preg, cdb_broadcast_valid, cdb_dest_preg_idx)) begin
      new_entry.opa_ready = 1'b1;
      new_entry.opa_value = cdb_broadcast_value;
    end
    if (cdb_hit(disp_pkt.opb_ready, disp_pkt.opb_preg, cdb_broadcast_valid, cdb_dest_preg_idx)) begin
      new_entry.opb_ready = 1'b1;
      new_entry.opb_value = cdb_broadcast_value;
    end
  end

  // Per-entry next state: wakeup, free on issue, allocate, then squash overrides validity.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid) begin
        if (cdb_hit(entries_q[i].opa_ready, entries_q[i].opa_preg,
                    cdb_broadcast_valid, cdb_dest_preg_idx)) begin
          entries_d[i].opa_ready = 1'b1;
          entries_d[i].opa_value = cdb_broadcast_value;
        end
        if (cdb_hit(entries_q[i].opb_ready, entries_q[i].opb_preg,
                    cdb_broadcast_valid, cdb_dest_preg_idx)) begin
          entries_d[i].opb_ready = 1'b1;
          entries_d[i].opb_value = cdb_broadcast_value;
        end
      end
      if (issue_fire && issue_gnt[i]) begin
        entries_d[i].valid = 1'b0;
      end
      if (alloc && alloc_gnt[i]) begin
        entries_d[i] = new_entry;
      end
      if (squash) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  // Occupancy: net of this cycle's allocation and issue; squash empties the station.
  always_comb begin
    if (squash) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(alloc) - CNT_W'(issue_fire);
    end
    full_d = (count_d == CNT_W'(RS_SIZE));
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign rs_full  = full_q;
  assign rs_count = count_q;

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios plus randomized traffic
// checked every cycle against a slot-level behavioural model.
module tb_rs_alu;

  logic        clock = 1'b0;
  logic        reset;
  logic        squash;
  logic        dispatch_valid;
  logic [4:0]  dispatch_func;
  logic        dispatch_opa_ready;
  logic [31:0] dispatch_opa_value;
  logic [5:0]  dispatch_opa_preg;
  logic        dispatch_opb_ready;
  logic [31:0] dispatch_opb_value;
  logic [5:0]  dispatch_opb_preg;
  logic [5:0]  dispatch_dest_preg;
  logic [4:0]  dispatch_rob_idx;
  logic [31:0] dispatch_PC;
  logic        cdb_broadcast_valid;
  logic [5:0]  cdb_dest_preg_idx;
  logic [31:0] cdb_broadcast_value;
  logic        issue_ready;
  logic        issue_valid;
  logic [4:0]  issue_func;
  logic [31:0] issue_opa;
  logic [31:0] issue_opb;
  logic [5:0]  issue_dest_preg;
  logic [4:0]  issue_rob_idx;
  logic [31:0] issue_PC;
  logic        rs_full;
  logic [3:0]  rs_count;

  rs_alu dut (
    .clock               (clock),
    .reset               (reset),
    .squash              (squash),
    .dispatch_valid      (dispatch_valid),
    .dispatch_func       (dispatch_func),
    .dispatch_opa_ready  (dispatch_opa_ready),
    .dispatch_opa_value  (dispatch_opa_value),
    .dispatch_opa_preg   (dispatch_opa_preg),
    .dispatch_opb_ready  (dispatch_opb_ready),
    .dispatch_opb_value  (dispatch_opb_value),
    .dispatch_opb_preg   (dispatch_opb_preg),
    .dispatch_dest_preg  (dispatch_dest_preg),
    .dispatch_rob_idx    (dispatch_rob_idx),
    .dispatch_PC         (dispatch_PC),
    .cdb_broadcast_valid (cdb_broadcast_valid),
    .cdb_dest_preg_idx   (cdb_dest_preg_idx),
    .cdb_broadcast_value (cdb_broadcast_value),
    .issue_ready         (issue_ready),
    .issue_valid         (issue_valid),
    .issue_func          (issue_func),
    .issue_opa           (issue_opa),
    .issue_opb           (issue_opb),
    .issue_dest_preg     (issue_dest_preg),
    .issue_rob_idx       (issue_rob_idx),
    .issue_PC            (issue_PC),
    .rs_full             (rs_full),
    .rs_count            (rs_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: eight slots, each simply "what op sits here and which operands are known".
  typedef struct {
    logic        valid;
    logic [4:0]  func;
    logic        ra;
    logic [31:0] va;
    logic [5:0]  pa;
    logic        rb;
    logic [31:0] vb;
    logic [5:0]  pb;
    logic [5:0]  dest;
    logic [4:0]  rob;
    logic [31:0] pc;
  } slot_t;

  slot_t m [8];
  int    m_count;
  int    exp_idx;
  logic  exp_vld;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m[i].valid = 1'b0;
    m_count = 0;
  endtask

  // Compare the DUT's current outputs with what the model says should be presented.
  task automatic compare_model();
    exp_idx = -1;
    for (int i = 0; i < 8; i++)
      if (exp_idx < 0 && m[i].valid && m[i].ra && m[i].rb) exp_idx = i;
    exp_vld = (exp_idx >= 0) && !squash;
    check_eq("issue_valid", 64'(issue_valid), 64'(exp_vld));
    if (exp_idx >= 0) begin
      check_eq("issue_func", 64'(issue_func),      64'(m[exp_idx].func));
      check_eq("issue_opa",  64'(issue_opa),       64'(m[exp_idx].va));
      check_eq("issue_opb",  64'(issue_opb),       64'(m[exp_idx].vb));
      check_eq("issue_dest", 64'(issue_dest_preg), 64'(m[exp_idx].dest));
      check_eq("issue_rob",  64'(issue_rob_idx),   64'(m[exp_idx].rob));
      check_eq("issue_pc",   64'(issue_PC),        64'(m[exp_idx].pc));
    end
    check_eq("rs_count", 64'(rs_count), 64'(m_count));
    check_eq("rs_full",  64'(rs_full),  64'(m_count == 8));
    if (dispatch_valid) check_eq("dispatch_while_full", 64'(rs_full), 64'(0));
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_update();
    int a;
    if (squash) begin
      model_clear();
      return;
    end
    a = -1;
    if (dispatch_valid && m_count < 8)
      for (int i = 0; i < 8; i++)
        if (a < 0 && !m[i].valid) a = i;
    for (int i = 0; i < 8; i++) begin
      if (m[i].valid && cdb_broadcast_valid) begin
        if (!m[i].ra && m[i].pa == cdb_dest_preg_idx) begin m[i].ra = 1'b1; m[i].va = cdb_broadcast_value; end
        if (!m[i].rb && m[i].pb == cdb_dest_preg_idx) begin m[i].rb = 1'b1; m[i].vb = cdb_broadcast_value; end
      end
    end
    if (exp_vld && issue_ready) begin
      m[exp_idx].valid = 1'b0;
      m_count--;
    end
    if (a >= 0) begin
      m[a].valid = 1'b1;
      m[a].func  = dispatch_func;
      m[a].ra    = dispatch_opa_ready;
      m[a].va    = dispatch_opa_value;
      m[a].pa    = dispatch_opa_preg;
      m[a].rb    = dispatch_opb_ready;
      m[a].vb    = dispatch_opb_value;
      m[a].pb    = dispatch_opb_preg;
      m[a].dest  = dispatch_dest_preg;
      m[a].rob   = dispatch_rob_idx;
      m[a].pc    = dispatch_PC;
      if (cdb_broadcast_valid && !m[a].ra && m[a].pa == cdb_dest_preg_idx) begin m[a].ra = 1'b1; m[a].va = cdb_broadcast_value; end
      if (cdb_broadcast_valid && !m[a].rb && m[a].pb == cdb_dest_preg_idx) begin m[a].rb = 1'b1; m[a].vb = cdb_broadcast_value; end
      m_count++;
    end
  endtask

  // Called at a negedge with inputs set: check, advance model, move to the next negedge.
  task automatic step();
    #1;
    compare_model();
    model_update();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clr();
    squash = 0; dispatch_valid = 0; dispatch_func = 0;
    dispatch_opa_ready = 0; dispatch_opa_value = 0; dispatch_opa_preg = 0;
    dispatch_opb_ready = 0; dispatch_opb_value = 0; dispatch_opb_preg = 0;
    dispatch_dest_preg = 0; dispatch_rob_idx = 0; dispatch_PC = 0;
    cdb_broadcast_valid = 0; cdb_dest_preg_idx = 0; cdb_broadcast_value = 0;
    issue_ready = 0;
  endtask

  task automatic disp(input logic ra, input logic [31:0] va, input logic [5:0] pa,
                      input logic rb, input logic [31:0] vb, input logic [5:0] pb,
                      input logic [5:0] dest, input logic [4:0] rob);
    dispatch_valid = 1; dispatch_func = 5'h01;
    dispatch_opa_ready = ra; dispatch_opa_value = va; dispatch_opa_preg = pa;
    dispatch_opb_ready = rb; dispatch_opb_value = vb; dispatch_opb_preg = pb;
    dispatch_dest_preg = dest; dispatch_rob_idx = rob; dispatch_PC = 32'h1000 + 32'(rob) * 4;
  endtask

  task automatic cdb(input logic [5:0] p, input logic [31:0] v);
    cdb_broadcast_valid = 1; cdb_dest_preg_idx = p; cdb_broadcast_value = v;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(issue_valid), 64'(0));
    check_eq({tag, "_fields"}, 64'(|{issue_func, issue_opa, issue_opb, issue_dest_preg, issue_rob_idx, issue_PC}), 64'(0));
    check_eq({tag, "_count"}, 64'(rs_count), 64'(0));
    check_eq({tag, "_full"}, 64'(rs_full), 64'(0));
  endtask

  initial begin
    clr();
    model_clear();
    reset = 0;
    #12;
    check_zero_outputs("reset");
    @(negedge clock);
    reset = 1;
    @(negedge clock);

    // Both operands ready: issues the next cycle and the station drains.
    disp(1, 5, 0, 1, 7, 0, 12, 3); issue_ready = 1;
    step();
    clr(); issue_ready = 1; #1;
    check_eq("t1_valid", 64'(issue_valid), 64'(1));
    check_eq("t1_opa", 64'(issue_opa), 64'(5));
    check_eq("t1_opb", 64'(issue_opb), 64'(7));
    check_eq("t1_dest", 64'(issue_dest_preg), 64'(12));
    check_eq("t1_rob", 64'(issue_rob_idx), 64'(3));
    step();
    clr(); #1;
    check_eq("t1_count", 64'(rs_count), 64'(0));
    step();

    // Operand A waits on preg 9; issue exactly one cycle after the broadcast.
    disp(0, 0, 9, 1, 2, 0, 13, 4);
    step();
    clr();
    step();
    cdb(9, 32'hdead); #1;
    check_eq("t2_not_yet", 64'(issue_valid), 64'(0));
    step();
    clr(); issue_ready = 1; #1;
    check_eq("t2_valid", 64'(issue_valid), 64'(1));
    check_eq("t2_opa", 64'(issue_opa), 64'(32'hdead));
    step();

    // Same-cycle dispatch and broadcast: bypass captures the value.
    clr(); disp(0, 0, 4, 1, 1, 0, 14, 5); cdb(4, 42);
    step();
    clr(); issue_ready = 1; #1;
    check_eq("t3_valid", 64'(issue_valid), 64'(1));
    check_eq("t3_opa", 64'(issue_opa), 64'(42));
    step();

    // Fill all eight slots with unresolved ops, free one, refill.
    for (int i = 0; i < 8; i++) begin
      clr(); disp(0, 0, 6'(40 + i), 1, 32'(i), 0, 6'(20 + i), 5'(i));
      step();
    end
    clr(); #1;
    check_eq("t4_full", 64'(rs_full), 64'(1));
    cdb(43, 32'h1234);
    step();
    clr(); issue_ready = 1; #1;
    check_eq("t4_issue_rob", 64'(issue_rob_idx), 64'(3));
    check_eq("t4_issue_opa", 64'(issue_opa), 64'(32'h1234));
    step();
    clr(); #1;
    check_eq("t4_not_full", 64'(rs_full), 64'(0));
    disp(0, 0, 50, 1, 0, 0, 30, 9);
    step();
    clr(); #1;
    check_eq("t4_refill_count", 64'(rs_count), 64'(8));
    check_eq("t4_refill_full", 64'(rs_full), 64'(1));
    squash = 1;
    step();

    // Backpressure: entry 0 stays presented while issue_ready is low.
    clr(); disp(1, 11, 0, 1, 12, 0, 1, 1);
    step();
    clr(); disp(1, 21, 0, 1, 22, 0, 2, 2);
    step();
    for (int i = 0; i < 3; i++) begin
      clr(); #1;
      check_eq("t5_hold_valid", 64'(issue_valid), 64'(1));
      check_eq("t5_hold_rob", 64'(issue_rob_idx), 64'(1));
      step();
    end
    clr(); issue_ready = 1; #1;
    check_eq("t5_fire_rob", 64'(issue_rob_idx), 64'(1));
    step();
    clr(); issue_ready = 1; #1;
    check_eq("t5_next_rob", 64'(issue_rob_idx), 64'(2));
    step();

    // Squash with five ready entries and a concurrent dispatch.
    for (int i = 0; i < 5; i++) begin
      clr(); disp(1, 32'(i), 0, 1, 0, 0, 6'(i), 5'(i));
      step();
    end
    clr(); squash = 1; issue_ready = 1; disp(1, 1, 0, 1, 1, 0, 1, 7); #1;
    check_eq("t6_squash_valid", 64'(issue_valid), 64'(0));
    step();
    clr(); #1;
    check_eq("t6_count", 64'(rs_count), 64'(0));
    check_eq("t6_valid_after", 64'(issue_valid), 64'(0));
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      clr();
      squash      = ($urandom_range(0, 49) == 0);
      issue_ready = ($urandom_range(0, 9) < 7);
      if (m_count < 8 && $urandom_range(0, 1) == 1)
        disp($urandom_range(0, 2) == 0, $urandom, 6'($urandom_range(0, 15)),
             $urandom_range(0, 2) == 0, $urandom, 6'($urandom_range(0, 15)),
             6'($urandom), 5'($urandom));
      if ($urandom_range(0, 1) == 1) cdb(6'($urandom_range(0, 15)), $urandom);
      step();
    end

    // Asynchronous reset in the middle of a cycle clears everything at once.
    clr();
    for (int i = 0; i < 3 && m_count < 8; i++) begin
      clr(); disp(1, 32'(i + 100), 0, 1, 5, 0, 6'(i), 5'(i));
      step();
    end
    clr(); #2;
    reset = 0; #1;
    check_zero_outputs("async_reset");
    model_clear();
    @(negedge clock);
    reset = 1;
    for (int c = 0; c < 200; c++) begin
      clr();
      issue_ready = ($urandom_range(0, 1) == 1);
      if (m_count < 8 && $urandom_range(0, 1) == 1)
        disp($urandom_range(0, 1) == 0, $urandom, 6'($urandom_range(0, 7)),
             $urandom_range(0, 1) == 0, $urandom, 6'($urandom_range(0, 7)),
             6'($urandom), 5'($urandom));
      if ($urandom_range(0, 1) == 1) cdb(6'($urandom_range(0, 7)), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
- ALU reservation station: one receiver of the registered common data bus (CDB) broadcast.
- Holds dispatched ALU ops until both source operands are available.
  - Captures operand values by snooping CDB physical-register tags.
  - Issues ready ops one per cycle to the ALU through a valid/ready handshake.
- Sits between the dispatch stage (upstream) and the ALU functional unit, whose result returns through the CDB arbiter.

Parameters:
- RS_SIZE, 8, number of entries (power of 2, ≥2).
- XLEN, 32, operand/value width.
- PRF_LEN, 6, physical register index width.
- ROB_LEN, 5, ROB index width.
- FUNC_LEN, 5, ALU function code width.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears state immediately).
- squash  in  1  ROB flush; clears all entries at next edge.
- dispatch_valid  in  1  new op present (never asserted while rs_full==1).
- dispatch_func  in  FUNC_LEN  ALU function.
- dispatch_opa_ready  in  1  operand A value valid.
- dispatch_opa_value  in  XLEN  operand A value.
- dispatch_opa_preg  in  PRF_LEN  operand A tag.
- dispatch_opb_ready  in  1  operand B value valid.
- dispatch_opb_value  in  XLEN  operand B value.
- dispatch_opb_preg  in  PRF_LEN  operand B tag.
- dispatch_dest_preg  in  PRF_LEN  destination tag.
- dispatch_rob_idx  in  ROB_LEN  ROB slot.
- dispatch_PC  in  XLEN  instruction PC.
- cdb_broadcast_valid  in  1  CDB carries a result this cycle.
- cdb_dest_preg_idx  in  PRF_LEN  broadcast tag.
- cdb_broadcast_value  in  XLEN  broadcast value.
- issue_ready  in  1  ALU accepts an op this cycle.
- issue_valid  out  1  op presented to ALU.
- issue_func  out  FUNC_LEN  function of issued op.
- issue_opa  out  XLEN  operand A value.
- issue_opb  out  XLEN  operand B value.
- issue_dest_preg  out  PRF_LEN  destination tag.
- issue_rob_idx  out  ROB_LEN  ROB slot.
- issue_PC  out  XLEN  PC.
- rs_full  out  1  registered; 1 when occupied count == RS_SIZE.
- rs_count  out  $clog2(RS_SIZE)+1  registered occupied count.

Behaviour:
- Reset (reset==0, asynchronous):
  - all entries invalid; rs_count=0, rs_full=0.
  - issue_valid=0 and all issue_* fields 0 (they are combinational from empty state).
- Entry state: valid, func, opa/opb ready+value+preg, dest_preg, rob_idx, PC.
- Allocation:
  - on dispatch_valid, the lowest-index invalid entry is written at the edge.
  - dispatch_valid while rs_full==1 is illegal; the bench asserts on it.
  - the RTL ignores such a dispatch.
- Wakeup, for each valid entry operand with ready==0:
  - if cdb_broadcast_valid and preg==cdb_dest_preg_idx, then at the edge ready<=1 and value<=cdb_broadcast_value.
- Dispatch bypass: if a dispatched operand has ready==0 and its preg matches a valid CDB broadcast in the same cycle, the entry is written with ready=1 and the CDB value. No lost wakeups.
- Ready operands never change value; a second matching broadcast is ignored.
- Selection and issue:
  - issue candidates are valid entries whose opa and opb ready flags are already set at the start of the cycle.
  - an op woken at edge N is issuable in cycle N+1 at earliest.
  - select the lowest-index candidate.
  - issue_* is combinational from that entry; issue_valid=1 iff a candidate exists and squash==0.
- Handshake:
  - the entry is freed at the edge where issue_valid && issue_ready.
  - if issue_ready==0, the same entry stays presented with fields stable. A lower-index entry may become ready and take priority next cycle.
- Count:
  - rs_count_next = rs_count + alloc − issue_fire.
  - simultaneous alloc and issue fire leaves the count unchanged.
  - rs_full is derived from rs_count_next and registered.
  - freeing an entry does not unblock dispatch in the same cycle.
- Squash (synchronous, highest priority):
  - at the edge all entries become invalid and rs_count=0.
  - a same-cycle dispatch is discarded; issue_valid is forced 0 during squash.
- Reset mid-operation discards everything; there is no partial state.

Decomposition:
- Shared package (sys_defs):
  - XLEN, PRF_LEN, ROB_LEN, FUNC_LEN, RS_ALU_SIZE.
  - ALU_FUNC enum.
  - typedef RS_ALU_ENTRY (struct of the entry fields above).
  - typedef RS_ALU_DISPATCH_PACKET (struct of the dispatch inputs).
- One natural sub-module, rs_psel: lowest-index priority selector (RS_SIZE wide) returning a one-hot grant plus an empty flag.
  - instantiated twice: free-entry allocation and ready-entry issue.

Test Plan:
- Dispatch with both operands ready (opa=5, opb=7, dest=12, rob=3), issue_ready=1 → issue_valid next cycle with opa=5, opb=7, dest=12, rob=3; rs_count returns to 0.
- Dispatch with opa waiting on preg 9; CDB broadcasts preg 9 value 0xdead two cycles later → issue_opa=0xdead, issue_valid asserted exactly one cycle after the broadcast.
- Dispatch waiting on preg 4 in the same cycle CDB broadcasts preg 4 value 42 → entry captures 42, issuable the next cycle (bypass).
- Fill 8 entries with unresolved operands → rs_full=1 after the 8th dispatch. One wakeup plus issue frees an entry → rs_full=0 the following cycle, then a new dispatch succeeds.
- Two ready entries, issue_ready held 0 for 3 cycles → entry 0 is presented stable throughout. On issue_ready=1, entry 0 fires and entry 1 is presented next.
- Five entries valid, squash=1 with a concurrent dispatch → issue_valid=0 that cycle; rs_count=0 and no entries valid after the edge. Async reset (reset=0) mid-stream → all outputs 0 immediately.
